muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO: single-cycle multiply,
// 32-step restoring divide, stalling the pipeline while busy.
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b, res_hi, res_lo;
  logic        mul_sgn, neg_q, neg_r;
  logic [5:0]  cnt;

  logic        start, hilo_wr, div_sel;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_res;
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] rem_nxt, quo_nxt;

  assign start   = ex_valid & ~cancel & (state == IDLE) &
                   (is_mult | is_multu | is_div | is_divu);
  assign hilo_wr = ex_valid & ~cancel & (state == IDLE) & ~start;
  assign div_sel = is_div | is_divu;

  // Only signed div takes magnitudes; divu passes operands through.
  assign a_neg = is_div & src_a[31];
  assign b_neg = is_div & src_b[31];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  assign mul_res = $signed({{32{mul_sgn & op_a[31]}}, op_a}) *
                   $signed({{32{mul_sgn & op_b[31]}}, op_b});

  // Restoring step: res_hi holds the partial remainder, res_lo shifts the
  // dividend out of its MSB and the quotient bits into its LSB.
  assign rem_sh  = {res_hi, res_lo[31]};
  assign diff    = rem_sh - {1'b0, op_b};
  assign q_bit   = ~diff[32];
  assign rem_nxt = q_bit ? diff[31:0] : rem_sh[31:0];
  assign quo_nxt = {res_lo[30:0], q_bit};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_sel ? DIV : MUL;
      MUL:     state_nxt = cancel ? IDLE : WB;
      DIV:     if (cancel) state_nxt = IDLE;
               else if (cnt == 6'd31) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall   = resetn & (start | (state == MUL) | (state == DIV));
  assign done    = (state == WB);
  assign product = done ? res_lo : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (div_sel) begin
              op_b   <= b_mag;
              res_lo <= a_mag;
              res_hi <= '0;
              // Divide-by-zero keeps the all-ones quotient unsigned.
              neg_q  <= (a_neg ^ b_neg) & (src_b != 32'd0);
              neg_r  <= a_neg;
            end else begin
              op_a    <= src_a;
              op_b    <= src_b;
              mul_sgn <= is_mult;
            end
          end else if (hilo_wr) begin
            if (hi_wen) hi <= src_a;
            if (lo_wen) lo <= src_a;
          end
        end
        MUL: {res_hi, res_lo} <= mul_res;
        DIV: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            res_lo <= neg_q ? -quo_nxt : quo_nxt;
            res_hi <= neg_r ? -rem_nxt : rem_nxt;
          end else begin
            res_lo <= quo_nxt;
            res_hi <= rem_nxt;
          end
        end
        WB: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected {product,hi,lo},
// monitor pops on done and checks the HI/LO commit one cycle later.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0;
  logic        is_mult = 1'b0, is_multu = 1'b0, is_div = 1'b0, is_divu = 1'b0;
  logic        hi_wen = 1'b0, lo_wen = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        cancel = 1'b0;
  logic        stall, done;
  logic [31:0] product, hi, lo;

  muldiv_unit dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid),
    .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stall(stall), .done(done), .product(product),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [95:0] exp_q[$];
  logic [95:0] mon_e;
  logic [31:0] pend_hi, pend_lo;
  bit          pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: result product on done, HI/LO at the following sample.
  always @(negedge clk) begin
    if (pend) begin
      chk("hi_commit", hi, pend_hi);
      chk("lo_commit", lo, pend_lo);
      pend = 1'b0;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 product=%h expected no result", product);
      end else begin
        mon_e = exp_q.pop_front();
        chk("product", product, mon_e[95:64]);
        pend_hi = mon_e[63:32];
        pend_lo = mon_e[31:0];
        pend    = 1'b1;
      end
    end
  end

  task automatic clear_ops();
    {is_div, is_divu, is_mult, is_multu} = 4'b0;
    ex_valid = 1'b0;
    hi_wen   = 1'b0;
    lo_wen   = 1'b0;
  endtask

  // ops = {div, divu, mult, multu}
  task automatic launch(input logic [3:0] ops, input logic [31:0] a, b,
                        input logic [31:0] ep, eh, el);
    {is_div, is_divu, is_mult, is_multu} = ops;
    src_a    = a;
    src_b    = b;
    ex_valid = 1'b1;
    exp_q.push_back({ep, eh, el});
  endtask

  // Counts stall cycles from the start cycle. mode 1: cancel during WB;
  // mode 2: mthi attempt during the first busy cycle.
  task automatic track(input int es, input int mode, input string nm);
    int n;
    bit fin;
    n = 0;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stall) n++;
      else fin = 1'b1;
      if (!fin) begin
        @(posedge clk); #1;
        clear_ops();
        if (mode == 2 && n == 1) begin
          ex_valid = 1'b1;
          hi_wen   = 1'b1;
          src_a    = 32'hDEADBEEF;
        end
      end
    end
    if (mode == 1) begin
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
    end
    chk(nm, 32'(n), 32'(es));
  endtask

  task automatic run_op(input logic [3:0] ops, input logic [31:0] a, b,
                        input logic [31:0] ep, eh, el, input int es,
                        input int mode, input string nm);
    @(posedge clk); #1;
    launch(ops, a, b, ep, eh, el);
    track(es, mode, nm);
  endtask

  initial begin
    // Reset: a start request must not raise stall while resetn is low.
    {is_multu, ex_valid} = 2'b11;
    src_a = 32'hFFFFFFFF;
    src_b = 32'hFFFFFFFF;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    exp_q.push_back({32'h00000001, 32'hFFFFFFFE, 32'h00000001});
    @(posedge clk); #2;
    resetn = 1'b1;
    track(2, 0, "stall_multu_first_edge");

    run_op(4'b0010, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 0, "stall_mult");
    run_op(4'b1000, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, "stall_div");
    run_op(4'b0100, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 33, 0, "stall_divu_by0");
    run_op(4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h80000000, 33, 0, "stall_div_ovf");
    run_op(4'b0100, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 33, 0, "stall_divu");
    run_op(4'b1000, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFD, 33, 0, "stall_div_negb");
    run_op(4'b1000, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 33, 0, "stall_div_by0");
    run_op(4'b1010, 32'd20, 32'd3, 32'd6, 32'd2, 32'd6, 33, 0, "stall_prio_div");
    run_op(4'b0110, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 33, 0, "stall_prio_divu");
    run_op(4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 2, 0, "stall_prio_mult");
    run_op(4'b0010, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 32'd0, 2, 2, "stall_mthi_busy");
    run_op(4'b0001, 32'd5, 32'd6, 32'd30, 32'd0, 32'd30, 2, 1, "stall_cancel_wb");

    // Cancel in IDLE suppresses both start and HI write.
    @(posedge clk); #1;
    ex_valid = 1'b1; is_mult = 1'b1; hi_wen = 1'b1; src_a = 32'h55; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    clear_ops(); cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_hi", hi, 32'd0);
    chk("cancel_idle_lo", lo, 32'd30);

    // mthi + mtlo in the same cycle.
    @(posedge clk); #1;
    ex_valid = 1'b1; hi_wen = 1'b1; lo_wen = 1'b1; src_a = 32'h12345678;
    @(posedge clk); #1;
    clear_ops();
    @(negedge clk);
    chk("mthilo_hi", hi, 32'h12345678);
    chk("mthilo_lo", lo, 32'h12345678);

    // Cancel in DIV cycle 10, then mtlo.
    @(posedge clk); #1;
    ex_valid = 1'b1; is_div = 1'b1; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    clear_ops();
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_div_busy", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_div_stall", {31'd0, stall}, 32'd0);
    chk("cancel_div_hi", hi, 32'h12345678);
    chk("cancel_div_lo", lo, 32'h12345678);
    @(posedge clk); #1;
    ex_valid = 1'b1; lo_wen = 1'b1; src_a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    clear_ops();
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hA5A5A5A5);
    chk("mtlo_hi", hi, 32'h12345678);

    // Reset during DIV cycle 20.
    @(posedge clk); #1;
    ex_valid = 1'b1; is_divu = 1'b1; src_a = 32'd1000; src_b = 32'd9;
    @(posedge clk); #1;
    clear_ops();
    repeat (19) @(posedge clk);
    #1;
    chk("div20_busy", {31'd0, stall}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_product", product, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    run_op(4'b0100, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 33, 0, "stall_after_midrst");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done: got %0d results outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
